// File: rtl/rv_pkg.sv
// Shared fetch-path constants and the fetch buffer entry type.
package rv_pkg;
  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] RESET_PC    = '0;
  localparam int              INSTR_BYTES = 4;

  // One buffered fetch: the instruction word tagged with its PC.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head reads 0 when empty.
module instr_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Entry storage; validity is carried by the pointers and count only.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, PC-tagged buffer,
// redirect on retiring branch with flush and drop of stale in-flight words.
// XLEN must match rv_pkg::XLEN since the buffer entry type comes from there.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);
  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam int              CW1  = CW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_q, drop_d, count;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_ok, retire, redirect, push;
  fetch_entry_t    push_entry, head;

  // Requests in flight plus buffered words never exceed DEPTH, so the
  // buffer cannot overflow. Held low throughout reset.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, count};
  assign imem_req_valid = RST && (credit_used < CW1'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (count != '0);
  assign retire      = instr_valid && instr_ready;
  assign redirect    = retire && PCSrc;
  assign target      = {PCTarget[XLEN-1:2], 2'b00};

  // Stray responses (nothing outstanding) are ignored; words from the old
  // stream, or arriving in the redirect cycle itself, are discarded.
  assign rsp_ok     = imem_rsp_valid && (outstanding_q != '0);
  assign push       = rsp_ok && (drop_q == '0) && !redirect;
  assign push_entry = '{instr: imem_rsp_data, pc: resp_pc_q};

  // Next-state for PCs and in-flight/drop counters; redirect overrides.
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
    if (push)     resp_pc_d  = resp_pc_q + STEP;
    if (redirect) begin
      drop_d     = outstanding_d;
      fetch_pc_d = target;
      resp_pc_d  = target;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) U0_instr_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (retire && !redirect),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count)
  );

  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = instr_valid ? (head.pc + STEP) : '0;

  // A response with nothing in flight means the memory broke protocol.
  a_rsp_tracked: assert property (@(posedge CLK) disable iff (!RST)
    imem_rsp_valid |-> (outstanding_q != '0));
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        RST;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        instr_valid, instr_ready, PCSrc;
  logic [31:0] instr, instr_pc, instr_pc_plus4, PCTarget;

  // second instance exercising address wrap from RESET_PC = 0xFFFF_FFFC
  logic        w_rst, w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready, w_pcsrc;
  logic [31:0] w_addr, w_rsp_data, w_instr, w_instr_pc, w_instr_pc4, w_target;

  int checks = 0, errors = 0, cyc = 0;
  int mem_mode = 0, mem_extra_max = 0;
  int rel_cyc = 0, first_valid_cyc = -1, ret_cnt = 0;
  logic [31:0] pend_a[$], req_log[$], ret_log[$], exp_q[$], w_log[$];
  int          pend_t[$], req_cyc_log[$];
  logic [31:0] model_pc;
  logic        prev_stall = 0, prev_redir = 0, w_pend_v = 0, w_seen = 0;
  logic [31:0] prev_addr, w_pend_a, w_first_pc, w_first_pc4;

  fetch_unit u_dut (
    .CLK(clk), .RST(RST),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(clk), .RST(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_pc_plus4(w_instr_pc4),
    .PCSrc(w_pcsrc), .PCTarget(w_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hBAD0_BAD0;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < req_cyc_log.size()) ? req_cyc_log[i] : -1;
  endfunction

  // PC retired right after the first retire of pc v
  function automatic logic [31:0] find_after(input logic [31:0] v);
    for (int i = 0; i + 1 < ret_log.size(); i++)
      if (ret_log[i] == v) return ret_log[i+1];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic bit req_has(input logic [31:0] v);
    foreach (req_log[i]) if (req_log[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // In-order instruction memory with randomizable ready and latency (>= 1 cycle).
  always @(negedge clk) begin
    if (!RST) begin
      pend_a.delete(); pend_t.delete();
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_data = '0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend_a.size() > 0 && pend_t[0] <= cyc && (mem_mode != 2 || $urandom_range(0, 3) != 0)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_a[0]);
        void'(pend_a.pop_front()); void'(pend_t.pop_front());
      end
      imem_req_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
      if (imem_req_valid && imem_req_ready) begin
        pend_a.push_back(imem_addr);
        pend_t.push_back(cyc + 1 + int'($urandom_range(0, mem_extra_max)));
        req_log.push_back(imem_addr);
        req_cyc_log.push_back(cyc);
      end
    end
  end

  // Memory for the wrap instance: always ready, fixed 1-cycle response.
  assign w_req_ready = 1'b1;
  always @(negedge clk) begin
    w_rsp_valid = w_pend_v;
    w_rsp_data  = mem_word(w_pend_a);
    w_pend_v    = w_rst && w_req_valid && w_req_ready;
    w_pend_a    = w_addr;
    if (w_pend_v) w_log.push_back(w_addr);
  end

  // Monitor: scoreboard pop on every retire, request-hold and empty-output checks.
  always @(negedge clk) begin
    #1;
    if (w_rst && w_instr_valid && !w_seen) begin
      w_seen = 1'b1; w_first_pc = w_instr_pc; w_first_pc4 = w_instr_pc4;
    end
    if (!RST) begin
      prev_stall = 1'b0;
    end else begin
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready) begin
        ret_cnt++;
        ret_log.push_back(instr_pc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: retire of pc 0x%08h with no expected entry", instr_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_instr", instr, mem_word(e));
          check("sb_pc_plus4", instr_pc_plus4, e + 32'd4);
        end
      end
      if (!instr_valid) check("empty_outputs_zero", instr | instr_pc | instr_pc_plus4, 32'h0);
      if (prev_stall && !prev_redir) begin
        check("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
        check("req_hold_addr", imem_addr, prev_addr);
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_addr;
      prev_redir = instr_valid && instr_ready && PCSrc;
    end
  end

  // Drive one cycle of downstream inputs; on a handshake, the reference
  // model advances the program-order PC and queues the next expected head.
  task automatic step(input bit rdy, input bit src, input logic [31:0] tgt);
    @(negedge clk);
    instr_ready = rdy; PCSrc = src; PCTarget = tgt;
    if (RST && instr_valid && rdy) begin
      model_pc = src ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
  endtask

  task automatic rst_assert();
    @(posedge clk); #2;
    RST = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0;
    exp_q.delete(); exp_q.push_back(32'h0); model_pc = 32'h0;
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    req_log.delete(); req_cyc_log.delete(); ret_log.delete();
    first_valid_cyc = -1; rel_cyc = cyc;
    RST = 1'b1;
  endtask

  initial begin
    int n0;
    RST = 1'b0; w_rst = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    w_instr_ready = 1'b1; w_pcsrc = 1'b0; w_target = '0;
    exp_q.push_back(32'h0); model_pc = 32'h0;

    repeat (3) @(negedge clk); #1;
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_plus4", instr_pc_plus4, 32'h0);

    // sequential fetch, latency, and the wrapping instance
    rst_release(); w_rst = 1'b1;
    repeat (8) step(1, 0, 0);
    check("seq_addr0", req_at(0), 32'h0);
    check("seq_addr1", req_at(1), 32'h4);
    check("seq_addr2", req_at(2), 32'h8);
    check("first_req_cycle", cyc_at(0), rel_cyc);
    check("req_to_valid_latency", first_valid_cyc - cyc_at(0), 32'd2);
    check("wrap_addr0", (w_log.size() > 0) ? w_log[0] : 32'hBAD0_BAD0, 32'hFFFF_FFFC);
    check("wrap_addr1", (w_log.size() > 1) ? w_log[1] : 32'hBAD0_BAD0, 32'h0);
    check("wrap_head_pc", w_seen ? w_first_pc : 32'hBAD0_BAD0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", w_seen ? w_first_pc4 : 32'hBAD0_BAD0, 32'h0);

    // downstream stall: exactly DEPTH requests, then clean drain
    rst_assert(); rst_release();
    repeat (10) step(0, 0, 0);
    #1;
    check("stall_req_count", req_log.size(), 32'd2);
    check("stall_req_valid_low", {31'h0, imem_req_valid}, 32'h0);
    check("stall_head_pc", instr_pc, 32'h0);
    check("stall_head_instr", instr, mem_word(32'h0));
    n0 = ret_cnt;
    repeat (10) step(1, 0, 0);
    check("drain_progress", {31'h0, (ret_cnt - n0) >= 4}, 32'h1);
    check("drain_first", (ret_log.size() > 1) ? ret_log[0] : 32'hBAD0_BAD0, 32'h0);
    check("drain_second", (ret_log.size() > 1) ? ret_log[1] : 32'hBAD0_BAD0, 32'h4);

    // memory back-pressure: address held, nothing skipped
    rst_assert(); rst_release();
    step(1, 0, 0); #1; mem_mode = 1;
    repeat (3) begin
      step(1, 0, 0); #1;
      check("bp_valid_high", {31'h0, imem_req_valid}, 32'h1);
      check("bp_addr_held", imem_addr, 32'h4);
    end
    mem_mode = 0;
    repeat (6) step(1, 0, 0);
    check("bp_addr0", req_at(0), 32'h0);
    check("bp_addr1", req_at(1), 32'h4);
    check("bp_addr2", req_at(2), 32'h8);

    // redirect at pc 0x8 to 0x100 with slower memory (stale words in flight)
    mem_extra_max = 1;
    rst_assert(); rst_release();
    for (int i = 0; i < 40; i++) step(1, model_pc == 32'h8, 32'h100);
    check("redir_target_0x100", find_after(32'h8), 32'h100);
    mem_extra_max = 0;

    // unaligned redirect target is word-aligned
    rst_assert(); rst_release();
    for (int i = 0; i < 20; i++) step(1, model_pc == 32'h4, 32'h202);
    check("redir_target_0x200", find_after(32'h4), 32'h200);
    check("fetch_addr_0x200", {31'h0, req_has(32'h200)}, 32'h1);

    // asynchronous reset mid-stream with a full buffer
    rst_assert(); rst_release();
    repeat (5) step(0, 0, 0);
    rst_assert(); #1;
    check("arst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("arst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", instr_pc, 32'h0);
    check("arst_pc_plus4", instr_pc_plus4, 32'h0);
    rst_release();
    repeat (3) step(1, 0, 0);
    check("arst_first_addr", req_at(0), 32'h0);
    check("arst_first_cycle", cyc_at(0), rel_cyc);

    // randomized traffic against the program-order model
    mem_mode = 2; mem_extra_max = 3;
    rst_assert(); rst_release();
    n0 = ret_cnt;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom);
    check("random_progress", {31'h0, (ret_cnt - n0) > 100}, 32'h1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
